// File: rtl/control_unit_pkg.sv
// Control unit shared types: FSM states, opcodes, ctrl strobe bit indices.
// Helper functions classify opcodes for the sequencer.
package control_unit_pkg;

  typedef enum logic [3:0] {
    RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam int CTRL_W = 27;

  localparam int C_PC_OUT   = 0;
  localparam int C_ZLO_OUT  = 1;
  localparam int C_ZHI_OUT  = 2;
  localparam int C_HI_OUT   = 3;
  localparam int C_LO_OUT   = 4;
  localparam int C_MDR_OUT  = 5;
  localparam int C_INP_OUT  = 6;
  localparam int C_CSX_OUT  = 7;
  localparam int C_R_OUT    = 8;
  localparam int C_BA_OUT   = 9;
  localparam int C_MAR_EN   = 10;
  localparam int C_MDR_EN   = 11;
  localparam int C_IR_EN    = 12;
  localparam int C_Y_EN     = 13;
  localparam int C_Z_EN     = 14;
  localparam int C_PC_EN    = 15;
  localparam int C_PC_INC   = 16;
  localparam int C_HI_EN    = 17;
  localparam int C_LO_EN    = 18;
  localparam int C_OUTP_EN  = 19;
  localparam int C_CON_EN   = 20;
  localparam int C_READ     = 21;
  localparam int C_RAM_WR   = 22;
  localparam int C_R_IN     = 23;
  localparam int C_GRA      = 24;
  localparam int C_GRB      = 25;
  localparam int C_GRC      = 26;

  // Unknown opcodes collapse to nop so decode never sees them.
  function automatic logic [4:0] op_norm(input logic [4:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_MUL, OP_DIV, OP_BR,
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_HALT:
        op_norm = op;
      default:
        op_norm = OP_NOP;
    endcase
  endfunction

  // Final execute state of each opcode; nop/halt end in T2.
  function automatic state_t op_last(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:
        op_last = T5;
      OP_LD, OP_ST:
        op_last = T7;
      OP_MUL, OP_DIV, OP_BR:
        op_last = T6;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:
        op_last = T3;
      default:
        op_last = T2;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Control unit: Moore sequencer T0..T7 for the datapath.
// Strobes decoded from state plus the opcode latched at T2->T3.
module control_unit
  import control_unit_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       ir,
  input  logic              con_ff,
  input  logic              stop,
  output logic              run,
  output logic [CTRL_W-1:0] ctrl
);

  state_t     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [4:0] ir_op;
  state_t     last_s, done_s;
  logic       unused_ir;

  assign ir_op     = op_norm(ir[31:27]);
  assign unused_ir = ^ir[26:0];
  assign last_s    = op_last(op_q);
  assign done_s    = stop ? HALT : T0;

  logic is_alu, is_imm, is_ldi, is_ld, is_st;
  logic is_md, is_br, is_jr, is_in, is_out;
  logic is_mfhi, is_mflo;

  assign is_alu  = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                   (op_q == OP_AND) || (op_q == OP_OR);
  assign is_imm  = (op_q == OP_ADDI) || (op_q == OP_ANDI) ||
                   (op_q == OP_ORI);
  assign is_ldi  = (op_q == OP_LDI);
  assign is_ld   = (op_q == OP_LD);
  assign is_st   = (op_q == OP_ST);
  assign is_md   = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign is_br   = (op_q == OP_BR);
  assign is_jr   = (op_q == OP_JR);
  assign is_in   = (op_q == OP_IN);
  assign is_out  = (op_q == OP_OUT);
  assign is_mfhi = (op_q == OP_MFHI);
  assign is_mflo = (op_q == OP_MFLO);

  // State and latched opcode; reset abandons any instruction at once.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= RESET;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next state: fetch, then execute up to the opcode's last state.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      RESET: state_d = T0;
      T0:    state_d = T1;
      T1:    state_d = T2;
      T2: begin
        op_d = ir_op;
        if (ir_op == OP_HALT)
          state_d = HALT;
        else if (ir_op == OP_NOP)
          state_d = done_s;
        else
          state_d = T3;
      end
      T3:    state_d = (last_s == T3) ? done_s : T4;
      T4:    state_d = (last_s == T4) ? done_s : T5;
      T5:    state_d = (last_s == T5) ? done_s : T6;
      T6:    state_d = (last_s == T6) ? done_s : T7;
      T7:    state_d = done_s;
      HALT:  state_d = HALT;
      default: state_d = RESET;
    endcase
  end

  // Strobe decode from state and latched opcode class.
  always_comb begin
    ctrl = '0;
    run  = (state_q != RESET) && (state_q != HALT);
    unique case (state_q)
      T0: begin
        ctrl[C_PC_OUT] = 1'b1;
        ctrl[C_MAR_EN] = 1'b1;
        ctrl[C_PC_INC] = 1'b1;
        ctrl[C_Z_EN]   = 1'b1;
      end
      T1: begin
        ctrl[C_ZLO_OUT] = 1'b1;
        ctrl[C_PC_EN]   = 1'b1;
        ctrl[C_READ]    = 1'b1;
        ctrl[C_MDR_EN]  = 1'b1;
      end
      T2: begin
        ctrl[C_MDR_OUT] = 1'b1;
        ctrl[C_IR_EN]   = 1'b1;
      end
      T3: begin
        unique case (1'b1)
          is_alu, is_imm: begin
            ctrl[C_GRB]   = 1'b1;
            ctrl[C_R_OUT] = 1'b1;
            ctrl[C_Y_EN]  = 1'b1;
          end
          is_ldi, is_ld, is_st: begin
            ctrl[C_GRB]    = 1'b1;
            ctrl[C_BA_OUT] = 1'b1;
            ctrl[C_Y_EN]   = 1'b1;
          end
          is_md: begin
            ctrl[C_GRA]   = 1'b1;
            ctrl[C_R_OUT] = 1'b1;
            ctrl[C_Y_EN]  = 1'b1;
          end
          is_br: begin
            ctrl[C_GRA]    = 1'b1;
            ctrl[C_R_OUT]  = 1'b1;
            ctrl[C_CON_EN] = 1'b1;
          end
          is_jr: begin
            ctrl[C_GRA]   = 1'b1;
            ctrl[C_R_OUT] = 1'b1;
            ctrl[C_PC_EN] = 1'b1;
          end
          is_in: begin
            ctrl[C_INP_OUT] = 1'b1;
            ctrl[C_GRA]     = 1'b1;
            ctrl[C_R_IN]    = 1'b1;
          end
          is_out: begin
            ctrl[C_GRA]     = 1'b1;
            ctrl[C_R_OUT]   = 1'b1;
            ctrl[C_OUTP_EN] = 1'b1;
          end
          is_mfhi: begin
            ctrl[C_HI_OUT] = 1'b1;
            ctrl[C_GRA]    = 1'b1;
            ctrl[C_R_IN]   = 1'b1;
          end
          is_mflo: begin
            ctrl[C_LO_OUT] = 1'b1;
            ctrl[C_GRA]    = 1'b1;
            ctrl[C_R_IN]   = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        unique case (1'b1)
          is_alu: begin
            ctrl[C_GRC]   = 1'b1;
            ctrl[C_R_OUT] = 1'b1;
            ctrl[C_Z_EN]  = 1'b1;
          end
          is_imm, is_ldi, is_ld, is_st: begin
            ctrl[C_CSX_OUT] = 1'b1;
            ctrl[C_Z_EN]    = 1'b1;
          end
          is_md: begin
            ctrl[C_GRB]   = 1'b1;
            ctrl[C_R_OUT] = 1'b1;
            ctrl[C_Z_EN]  = 1'b1;
          end
          is_br: begin
            ctrl[C_PC_OUT] = 1'b1;
            ctrl[C_Y_EN]   = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        unique case (1'b1)
          is_alu, is_imm, is_ldi: begin
            ctrl[C_ZLO_OUT] = 1'b1;
            ctrl[C_GRA]     = 1'b1;
            ctrl[C_R_IN]    = 1'b1;
          end
          is_ld, is_st: begin
            ctrl[C_ZLO_OUT] = 1'b1;
            ctrl[C_MAR_EN]  = 1'b1;
          end
          is_md: begin
            ctrl[C_ZLO_OUT] = 1'b1;
            ctrl[C_LO_EN]   = 1'b1;
          end
          is_br: begin
            ctrl[C_CSX_OUT] = 1'b1;
            ctrl[C_Z_EN]    = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        unique case (1'b1)
          is_ld: begin
            ctrl[C_READ]   = 1'b1;
            ctrl[C_MDR_EN] = 1'b1;
          end
          is_st: begin
            ctrl[C_GRA]    = 1'b1;
            ctrl[C_R_OUT]  = 1'b1;
            ctrl[C_MDR_EN] = 1'b1;
          end
          is_md: begin
            ctrl[C_ZHI_OUT] = 1'b1;
            ctrl[C_HI_EN]   = 1'b1;
          end
          is_br: begin
            ctrl[C_ZLO_OUT] = con_ff;
            ctrl[C_PC_EN]   = con_ff;
          end
          default: ;
        endcase
      end
      T7: begin
        unique case (1'b1)
          is_ld: begin
            ctrl[C_MDR_OUT] = 1'b1;
            ctrl[C_GRA]     = 1'b1;
            ctrl[C_R_IN]    = 1'b1;
          end
          is_st: ctrl[C_RAM_WR] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, randomized
// instruction stream against a strobe-table model, reset/halt/stop cases.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
  logic        run;
  logic [26:0] ctrl;

  control_unit dut (
    .clk    (clk),
    .clr    (clr),
    .ir     (ir),
    .con_ff (con_ff),
    .stop   (stop),
    .run    (run),
    .ctrl   (ctrl)
  );

  always #5 clk = ~clk;

  localparam logic [26:0] PC_OUT  = 27'd1 << 0;
  localparam logic [26:0] ZLO_OUT = 27'd1 << 1;
  localparam logic [26:0] ZHI_OUT = 27'd1 << 2;
  localparam logic [26:0] HI_OUT  = 27'd1 << 3;
  localparam logic [26:0] LO_OUT  = 27'd1 << 4;
  localparam logic [26:0] MDR_OUT = 27'd1 << 5;
  localparam logic [26:0] INP_OUT = 27'd1 << 6;
  localparam logic [26:0] CSX_OUT = 27'd1 << 7;
  localparam logic [26:0] R_OUT   = 27'd1 << 8;
  localparam logic [26:0] BA_OUT  = 27'd1 << 9;
  localparam logic [26:0] MAR_EN  = 27'd1 << 10;
  localparam logic [26:0] MDR_EN  = 27'd1 << 11;
  localparam logic [26:0] IR_EN   = 27'd1 << 12;
  localparam logic [26:0] Y_EN    = 27'd1 << 13;
  localparam logic [26:0] Z_EN    = 27'd1 << 14;
  localparam logic [26:0] PC_EN   = 27'd1 << 15;
  localparam logic [26:0] PC_INC  = 27'd1 << 16;
  localparam logic [26:0] HI_EN   = 27'd1 << 17;
  localparam logic [26:0] LO_EN   = 27'd1 << 18;
  localparam logic [26:0] OUTP_EN = 27'd1 << 19;
  localparam logic [26:0] CON_EN  = 27'd1 << 20;
  localparam logic [26:0] READ    = 27'd1 << 21;
  localparam logic [26:0] RAM_WR  = 27'd1 << 22;
  localparam logic [26:0] R_IN    = 27'd1 << 23;
  localparam logic [26:0] GRA     = 27'd1 << 24;
  localparam logic [26:0] GRB     = 27'd1 << 25;
  localparam logic [26:0] GRC     = 27'd1 << 26;

  localparam logic [26:0] F0 = PC_OUT | MAR_EN | PC_INC | Z_EN;
  localparam logic [26:0] F1 = ZLO_OUT | PC_EN | READ | MDR_EN;
  localparam logic [26:0] F2 = MDR_OUT | IR_EN;
  localparam logic [26:0] Z0 = 27'd0;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0]      ir;
    logic             con;
    int               n;
    logic [4:0][26:0] ex;
    string            nm;
  } vec_t;

  vec_t tbl[8];

  logic [26:0] mseq[5];
  int          mlen;

  function automatic vec_t mk(input logic [31:0] i, input logic c,
                              input int n, input logic [26:0] e0,
                              input logic [26:0] e1, input logic [26:0] e2,
                              input logic [26:0] e3, input logic [26:0] e4,
                              input string nm);
    vec_t v;
    v.ir = i;
    v.con = c;
    v.n = n;
    v.ex[0] = e0;
    v.ex[1] = e1;
    v.ex[2] = e2;
    v.ex[3] = e3;
    v.ex[4] = e4;
    v.nm = nm;
    return v;
  endfunction

  // Execute-phase strobe list per opcode, straight from the opcode tables.
  task automatic model(input logic [4:0] op, input logic con);
    logic [26:0] s[$];
    s = {};
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6:
        s = {GRB | R_OUT | Y_EN, GRC | R_OUT | Z_EN, ZLO_OUT | GRA | R_IN};
      5'd12, 5'd13, 5'd14:
        s = {GRB | R_OUT | Y_EN, CSX_OUT | Z_EN, ZLO_OUT | GRA | R_IN};
      5'd1:
        s = {GRB | BA_OUT | Y_EN, CSX_OUT | Z_EN, ZLO_OUT | GRA | R_IN};
      5'd0:
        s = {GRB | BA_OUT | Y_EN, CSX_OUT | Z_EN, ZLO_OUT | MAR_EN,
             READ | MDR_EN, MDR_OUT | GRA | R_IN};
      5'd2:
        s = {GRB | BA_OUT | Y_EN, CSX_OUT | Z_EN, ZLO_OUT | MAR_EN,
             GRA | R_OUT | MDR_EN, RAM_WR};
      5'd15, 5'd16:
        s = {GRA | R_OUT | Y_EN, GRB | R_OUT | Z_EN, ZLO_OUT | LO_EN,
             ZHI_OUT | HI_EN};
      5'd18:
        s = {GRA | R_OUT | CON_EN, PC_OUT | Y_EN, CSX_OUT | Z_EN,
             con ? (ZLO_OUT | PC_EN) : Z0};
      5'd19: s = {GRA | R_OUT | PC_EN};
      5'd21: s = {INP_OUT | GRA | R_IN};
      5'd22: s = {GRA | R_OUT | OUTP_EN};
      5'd23: s = {HI_OUT | GRA | R_IN};
      5'd24: s = {LO_OUT | GRA | R_IN};
      default: s = {};
    endcase
    mlen = s.size();
    for (int k = 0; k < 5; k++)
      mseq[k] = (k < mlen) ? s[k] : Z0;
  endtask

  task automatic chk(input string nm, input logic r, input logic [26:0] c,
                     input logic er, input logic [26:0] ec);
    n_chk++;
    if (r !== er || c !== ec) begin
      n_fail++;
      $display("FAIL %s: got run=%b ctrl=%h, expected run=%b ctrl=%h",
               nm, r, c, er, ec);
    end
  endtask

  // One clock: drive inputs just after the edge, compare mid-cycle.
  task automatic step(input logic [31:0] iv, input logic cv,
                      input logic sv, input logic [26:0] ec,
                      input logic er, input string nm);
    @(posedge clk);
    #1;
    ir = iv;
    con_ff = cv;
    stop = sv;
    #1;
    chk(nm, run, ctrl, er, ec);
  endtask

  task automatic fetch(input logic [31:0] iv, input logic cv,
                       input logic s2, input string nm);
    step(iv, cv, 1'b0, F0, 1'b1, {nm, "_T0"});
    step(iv, cv, 1'b0, F1, 1'b1, {nm, "_T1"});
    step(iv, cv, s2, F2, 1'b1, {nm, "_T2"});
  endtask

  task automatic run_instr(input logic [31:0] iv, input logic cv,
                           input logic stp, input string nm);
    model(iv[31:27], cv);
    fetch(iv, cv, stp && (mlen == 0), nm);
    for (int k = 0; k < mlen; k++)
      step(iv, cv, stp && (k == mlen - 1), mseq[k], 1'b1,
           $sformatf("%s_T%0d", nm, k + 3));
  endtask

  // Pulse clr low for one cycle, then check the single RESET cycle.
  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    clr = 1'b0;
    #1;
    chk({nm, "_asserted"}, run, ctrl, 1'b0, Z0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    stop = 1'b0;
    #1;
    chk({nm, "_reset_cycle"}, run, ctrl, 1'b0, Z0);
  endtask

  initial begin
    clr = 1'b0;
    ir = 32'h0;
    con_ff = 1'b0;
    stop = 1'b0;
    #2;
    chk("reset_state", run, ctrl, 1'b0, Z0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    chk("reset_cycle", run, ctrl, 1'b0, Z0);

    tbl[0] = mk(32'h0A00000F, 1'b0, 6, GRB | BA_OUT | Y_EN,
                CSX_OUT | Z_EN, ZLO_OUT | GRA | R_IN, Z0, Z0, "ldi");
    tbl[1] = mk(32'h6200000A, 1'b0, 6, GRB | R_OUT | Y_EN,
                CSX_OUT | Z_EN, ZLO_OUT | GRA | R_IN, Z0, Z0, "addi");
    tbl[2] = mk(32'h90000004, 1'b0, 7, GRA | R_OUT | CON_EN,
                PC_OUT | Y_EN, CSX_OUT | Z_EN, Z0, Z0, "br_nt");
    tbl[3] = mk(32'h90000004, 1'b1, 7, GRA | R_OUT | CON_EN,
                PC_OUT | Y_EN, CSX_OUT | Z_EN, ZLO_OUT | PC_EN, Z0, "br_t");
    tbl[4] = mk(32'h78000000, 1'b0, 7, GRA | R_OUT | Y_EN,
                GRB | R_OUT | Z_EN, ZLO_OUT | LO_EN, ZHI_OUT | HI_EN, Z0,
                "mul");
    tbl[5] = mk(32'h00000000, 1'b0, 8, GRB | BA_OUT | Y_EN,
                CSX_OUT | Z_EN, ZLO_OUT | MAR_EN, READ | MDR_EN,
                MDR_OUT | GRA | R_IN, "ld");
    tbl[6] = mk(32'h10000000, 1'b0, 8, GRB | BA_OUT | Y_EN,
                CSX_OUT | Z_EN, ZLO_OUT | MAR_EN, GRA | R_OUT | MDR_EN,
                RAM_WR, "st");
    tbl[7] = mk(32'hF8000000, 1'b0, 3, Z0, Z0, Z0, Z0, Z0, "bad_op");

    for (int i = 0; i < 8; i++) begin
      fetch(tbl[i].ir, tbl[i].con, 1'b0, tbl[i].nm);
      for (int k = 0; k < tbl[i].n - 3; k++)
        step(tbl[i].ir, tbl[i].con, 1'b0, tbl[i].ex[k], 1'b1,
             $sformatf("%s_T%0d", tbl[i].nm, k + 3));
    end

    for (int i = 0; i < 40; i++) begin
      logic [4:0]  op;
      logic [31:0] iv;
      logic        cv;
      op = 5'($urandom_range(0, 31));
      if (op == 5'd26)
        op = 5'd25;
      iv = {op, 27'($urandom)};
      cv = 1'($urandom);
      run_instr(iv, cv, 1'b0, $sformatf("rnd%0d_op%0d", i, op));
    end

    model(5'd0, 1'b0);
    fetch(32'h00000000, 1'b0, 1'b0, "ldrst");
    for (int k = 0; k < 3; k++)
      step(32'h0, 1'b0, 1'b0, mseq[k], 1'b1,
           $sformatf("ldrst_T%0d", k + 3));
    step(32'h0, 1'b0, 1'b0, READ | MDR_EN, 1'b1, "ldrst_T6");
    clr = 1'b0;
    #1;
    chk("ldrst_async_clear", run, ctrl, 1'b0, Z0);
    @(posedge clk);
    #1;
    chk("ldrst_held", run, ctrl, 1'b0, Z0);
    clr = 1'b1;
    #1;
    chk("ldrst_reset_cycle", run, ctrl, 1'b0, Z0);
    fetch(32'hC8000000, 1'b0, 1'b0, "after_rst_nop");

    run_instr(32'hD0000000, 1'b0, 1'b0, "halt");
    for (int k = 0; k < 20; k++)
      step(32'h18000000, 1'b1, 1'b0, Z0, 1'b0,
           $sformatf("halt_hold%0d", k));
    do_reset("halt_rst");

    run_instr(32'h18000000, 1'b0, 1'b1, "add_stop");
    for (int k = 0; k < 3; k++)
      step(32'h18000000, 1'b0, 1'b0, Z0, 1'b0,
           $sformatf("stop_halt%0d", k));
    do_reset("stop_rst");
    run_instr(32'h98000000, 1'b0, 1'b0, "jr_final");
    step(32'h0, 1'b0, 1'b0, F0, 1'b1, "final_T0");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
